// File: rtl/tx_pts_pkg.sv
// Shared types and helpers for the USB transmit parallel-to-serial stuffer.
package tx_pts_pkg;

  localparam int ONES_W    = 3;
  localparam int MAX_WIDTH = 64;
  localparam int IDX_W     = $clog2(MAX_WIDTH);

  typedef enum logic {
    LINE_K = 1'b0,
    LINE_J = 1'b1
  } nrzi_line_t;

  // Words narrower than MAX_WIDTH are zero-extended by the caller.
  function automatic logic next_bit(input logic [MAX_WIDTH-1:0] sr,
                                    input logic [IDX_W-1:0]     msb_idx,
                                    input logic                 msb_first);
    return msb_first ? sr[msb_idx] : sr[0];
  endfunction

endpackage

// File: rtl/tx_pts_stuffer_nrzi.sv
// NRZI line register for the transmit stuffer: toggles on every emitted 0.
module tx_nrzi_enc
  import tx_pts_pkg::*;
(
  input  logic clk,
  input  logic n_rst,
  input  logic bit_strobe,
  input  logic bit_in,
  output logic line_out
);

  nrzi_line_t line;

  always_ff @(posedge clk) begin
    if (n_rst) begin
      line <= LINE_J;
    end else if (bit_strobe && !bit_in) begin
      line <= (line == LINE_J) ? LINE_K : LINE_J;
    end
  end

  assign line_out = line;

endmodule

// File: rtl/tx_pts_stuffer.sv
// Double-buffered parallel-to-serial shifter with USB bit stuffing.
// Optional NRZI line encoding is enabled by defining TX_PTS_NRZI_EN.
module tx_pts_stuffer
  import tx_pts_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter int   MSB_FIRST = 0,
  parameter logic IDLE_BIT  = 1'b1,
  parameter int   STUFF_LEN = 6
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             shift_enable,
  input  logic             data_valid,
  input  logic [WIDTH-1:0] data_in,
  output logic             data_ready,
  output logic             serial_out,
  output logic             stuff_active,
  output logic             word_done,
  output logic             busy
);

  localparam int                CNT_W     = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(WIDTH - 1);
  localparam logic [ONES_W-1:0] STUFF_CNT = ONES_W'(STUFF_LEN);

  logic [WIDTH-1:0]  sr;
  logic [WIDTH-1:0]  hold;
  logic [WIDTH-1:0]  sr_shifted;
  logic [CNT_W-1:0]  bit_cnt;
  logic [ONES_W-1:0] ones_cnt;
  logic              active;
  logic              hold_full;
  logic              out_q;
  logic              accept;
  logic              stuff_now;
  logic              last_emit;
  logic              data_bit;
  logic              emit_bit;

  assign data_ready = !hold_full;
  assign accept     = data_valid && !hold_full;
  assign stuff_now  = (ones_cnt == STUFF_CNT);
  assign busy       = active | stuff_now;
  assign data_bit   = next_bit(MAX_WIDTH'(sr), IDX_W'(WIDTH - 1), MSB_FIRST != 0);
  assign sr_shifted = (MSB_FIRST != 0) ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
  assign last_emit  = shift_enable && !stuff_now && active && (bit_cnt == LAST_CNT);
  assign emit_bit   = stuff_now ? 1'b0 : (active ? data_bit : IDLE_BIT);

  always_ff @(posedge clk) begin
    if (n_rst) begin
      sr           <= '0;
      hold         <= '0;
      bit_cnt      <= '0;
      ones_cnt     <= '0;
      active       <= 1'b0;
      hold_full    <= 1'b0;
      out_q        <= IDLE_BIT;
      stuff_active <= 1'b0;
      word_done    <= 1'b0;
    end else begin
      stuff_active <= 1'b0;
      word_done    <= 1'b0;
      if (shift_enable) begin
        out_q <= emit_bit;
        if (stuff_now) begin
          ones_cnt     <= '0;
          stuff_active <= 1'b1;
        end else if (active) begin
          sr       <= sr_shifted;
          bit_cnt  <= bit_cnt + 1'b1;
          ones_cnt <= data_bit ? ones_cnt + 1'b1 : '0;
          if (bit_cnt == LAST_CNT) begin
            word_done <= 1'b1;
            if (hold_full) begin
              sr        <= hold;
              bit_cnt   <= '0;
              hold_full <= 1'b0;
            end else if (!accept) begin
              active <= 1'b0;
            end
          end
        end else begin
          ones_cnt <= '0;
        end
      end
      // A word arriving as the last bit leaves goes straight into sr (zero gap).
      if (accept) begin
        if (!active || last_emit) begin
          sr      <= data_in;
          bit_cnt <= '0;
          active  <= 1'b1;
        end else begin
          hold      <= data_in;
          hold_full <= 1'b1;
        end
      end
    end
  end

`ifdef TX_PTS_NRZI_EN
  logic line_bit;

  tx_nrzi_enc u_nrzi (
    .clk        (clk),
    .n_rst      (n_rst),
    .bit_strobe (shift_enable && (stuff_now || active)),
    .bit_in     (emit_bit),
    .line_out   (line_bit)
  );

  assign serial_out = line_bit;
`else
  assign serial_out = out_q;
`endif

endmodule

// File: tb/tb_tx_pts_stuffer.sv
// Scoreboard bench for tx_pts_stuffer: a bit-stream reference model predicts
// every cycle's outputs, a separate monitor compares them one step after the edge.
module tb_tx_pts_stuffer;

  localparam int WIDTH     = 8;
  localparam int STUFF_LEN = 6;

  logic             clk = 1'b0;
  logic             n_rst;
  logic             shift_enable;
  logic             data_valid;
  logic [WIDTH-1:0] data_in;
  logic             data_ready;
  logic             serial_out;
  logic             stuff_active;
  logic             word_done;
  logic             busy;

  int checks   = 0;
  int failures = 0;
  int strobe_mode = 0;
  bit armed = 1'b0;

  typedef struct packed {
    logic serial;
    logic stuff;
    logic done;
    logic ready;
    logic busy;
  } exp_t;

  exp_t expq[$];

  always #5 clk = ~clk;

  tx_pts_stuffer #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (0),
    .IDLE_BIT  (1'b1),
    .STUFF_LEN (STUFF_LEN)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .shift_enable (shift_enable),
    .data_valid   (data_valid),
    .data_in      (data_in),
    .data_ready   (data_ready),
    .serial_out   (serial_out),
    .stuff_active (stuff_active),
    .word_done    (word_done),
    .busy         (busy)
  );

  // Reference model: accepted words become a FIFO of raw bits; each strobe owes
  // either a stuffed 0, the next raw bit, or the idle level.
  bit bitq[$];
  bit lastq[$];
  int ones    = 0;
  bit out_lvl = 1'b1;
  bit line    = 1'b1;

  always @(posedge clk) begin : model
    bit rst, se, dv, rdy, acc, b;
    logic [WIDTH-1:0] din;
    int words;
    exp_t e;
    rst = n_rst;
    se  = shift_enable;
    dv  = data_valid;
    din = data_in;
    words = 0;
    foreach (lastq[k]) if (lastq[k]) words++;
    rdy = (words < 2);
    if (rst) armed = 1'b1;
    if (armed) begin
      e = '0;
      if (rst) begin
        bitq.delete();
        lastq.delete();
        ones    = 0;
        out_lvl = 1'b1;
        line    = 1'b1;
      end else begin
        acc = dv && rdy;
        if (se) begin
          if (ones == STUFF_LEN) begin
            out_lvl = 1'b0;
            ones    = 0;
            e.stuff = 1'b1;
            line    = ~line;
          end else if (bitq.size() > 0) begin
            b       = bitq.pop_front();
            e.done  = lastq.pop_front();
            out_lvl = b;
            ones    = b ? ones + 1 : 0;
            if (!b) line = ~line;
          end else begin
            out_lvl = 1'b1;
            ones    = 0;
          end
        end
        if (acc) begin
          for (int i = 0; i < WIDTH; i++) begin
            bitq.push_back(din[i]);
            lastq.push_back(i == WIDTH - 1);
          end
        end
      end
      words = 0;
      foreach (lastq[k]) if (lastq[k]) words++;
      e.ready = (words < 2);
      e.busy  = (bitq.size() > 0) || (ones == STUFF_LEN);
`ifdef TX_PTS_NRZI_EN
      e.serial = line;
`else
      e.serial = out_lvl;
`endif
      expq.push_back(e);
    end
  end

  task automatic checkOutput(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (armed) begin
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL scoreboard_empty at %0t: got no entry expected one", $time);
      end else begin
        e = expq.pop_front();
        checkOutput("serial_out",   serial_out,   e.serial);
        checkOutput("stuff_active", stuff_active, e.stuff);
        checkOutput("word_done",    word_done,    e.done);
        checkOutput("data_ready",   data_ready,   e.ready);
        checkOutput("busy",         busy,         e.busy);
      end
    end
  end

  initial begin : strobe_gen
    int cnt;
    cnt = 0;
    shift_enable = 1'b0;
    forever begin
      @(negedge clk);
      cnt++;
      case (strobe_mode)
        0:       shift_enable = (cnt % 4 == 0);
        1:       shift_enable = ($urandom_range(0, 2) == 0);
        default: shift_enable = 1'b0;
      endcase
    end
  end

  task automatic applyStimulus(input logic [WIDTH-1:0] w);
    bit rdy;
    bit taken;
    taken = 1'b0;
    @(negedge clk);
    data_valid = 1'b1;
    data_in    = w;
    for (int i = 0; i < 200 && !taken; i++) begin
      rdy = data_ready;
      @(posedge clk);
      if (rdy) taken = 1'b1;
    end
    if (!taken) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout: got no accept expected accept of %h", w);
    end
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  initial begin
    n_rst      = 1'b1;
    data_valid = 1'b0;
    data_in    = '0;
    repeat (2) @(negedge clk);
    n_rst = 1'b0;

    $display("[TB] directed words");
    applyStimulus(8'hA5);
    repeat (50) @(negedge clk);
    applyStimulus(8'hFF);
    repeat (50) @(negedge clk);
    applyStimulus(8'h3F);
    applyStimulus(8'h81);
    repeat (80) @(negedge clk);
    applyStimulus(8'hFC);
    repeat (60) @(negedge clk);
    applyStimulus(8'h00);
    repeat (50) @(negedge clk);

    $display("[TB] reset mid-word");
    applyStimulus(8'h5A);
    applyStimulus(8'hC3);
    repeat (10) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    n_rst = 1'b0;
    repeat (10) @(negedge clk);

    $display("[TB] random traffic");
    strobe_mode = 1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      data_valid = ($urandom_range(0, 2) != 0);
      data_in    = WIDTH'($urandom);
      if ($urandom_range(0, 3) == 0) data_in = 8'hFF;
      n_rst      = ($urandom_range(0, 399) == 0);
    end
    @(negedge clk);
    n_rst      = 1'b0;
    data_valid = 1'b0;
    repeat (150) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tx_pts_stuffer.md
Name: tx_pts_stuffer

Overview:
- Parametrised, double-buffered parallel-to-serial shifter for the USB transmit path; successor to the fixed 8-bit PTS shift register.
- Accepts words over a valid/ready handshake and serialises them back-to-back, LSB-first by default.
- Inserts USB bit-stuffing: a forced 0 after six consecutive 1s.
- Sits between the transmit controller/FIFO and the line-driver encoder; bit timing comes from an external shift_enable strobe.

Parameters:
- WIDTH, 8: word width in bits (>=2).
- MSB_FIRST, 0: 0 = bit 0 sent first; 1 = bit WIDTH-1 sent first.
- IDLE_BIT, 1: level driven when no word and no stuff bit is pending.
- STUFF_LEN, 6: run of consecutive 1s that triggers a stuffed 0 (1..7).

Ports:
- clk  in  1  system clock, all state on rising edge.
- n_rst  in  1  reset: synchronous, active-high (asserted = 1 clears state on the next clk edge). Name kept per codebase port naming.
- shift_enable  in  1  one-cycle bit-period strobe.
- data_valid  in  1  data_in holds a word to send.
- data_in  in  WIDTH  parallel word.
- data_ready  out  1  word accepted when data_valid && data_ready.
- serial_out  out  1  registered serial bit.
- stuff_active  out  1  1-cycle pulse: a stuffed 0 was emitted this edge.
- word_done  out  1  1-cycle pulse: last data bit of a word was emitted.
- busy  out  1  active word or stuff pending.

Behaviour:
- State:
  - sr[WIDTH]: active shift word.
  - bit_cnt: 0..WIDTH-1.
  - active.
  - hold[WIDTH] + hold_full: second buffer.
  - ones_cnt: 3 bits.
  - out_q: drives serial_out.
- Reset values: out_q = IDLE_BIT, data_ready = 1, stuff_active = 0, word_done = 0, busy = 0; all counters and flags 0. Reset mid-word discards sr and hold with no partial flush.
- Handshake:
  - data_ready = !hold_full (combinational from the register).
  - On accept: if !active, or the last bit is emitted this same cycle with hold empty, data_in loads sr, bit_cnt = 0, active = 1. Otherwise data_in loads hold and hold_full = 1.
- Shift cycle (shift_enable = 1), evaluated in priority order:
  1. ones_cnt == STUFF_LEN: out_q = 0, ones_cnt = 0, stuff_active = 1. sr and bit_cnt do not advance. This rule applies whether or not active is set, so a stuff owed after a word's final bit is still sent.
  2. active: out_q = next bit (sr[0], or sr[WIDTH-1] when MSB_FIRST = 1), then shift. ones_cnt = bit ? ones_cnt + 1 : 0. bit_cnt++.
     - If bit_cnt == WIDTH-1: word_done = 1. If hold_full, move hold to sr, bit_cnt = 0, hold_full = 0, active stays 1 (zero gap). Otherwise active = 0, unless a same-cycle accept applies.
  3. Idle: out_q = IDLE_BIT, ones_cnt = 0.
- No shift_enable: out_q holds and no pulses fire. Loads still proceed.
- Latency: serial_out shows a bit one clk after its shift_enable. First data bit appears on the first shift_enable after the accept edge.
- The ones run spans word boundaries. Stuffing is computed on raw bits.
- busy = active | (ones_cnt == STUFF_LEN).

Optional Feature:
- Macro: TX_PTS_NRZI_EN.
- Defined: serial_out is NRZI-encoded. A line register toggles on each emitted 0 (data or stuffed) and holds on each 1. Idle emits a 1, so the line holds. Line register resets to 1 (J).
- Undefined: serial_out = out_q (raw NRZ). The NRZI register is not instantiated.

Decomposition:
- Package tx_pts_pkg holds:
  - localparam ONES_W = 3.
  - Function next_bit(sr, msb_first).
  - typedef for the NRZI line state.
- One natural sub-module: tx_nrzi_enc (1-bit toggle register, clk/n_rst/bit_strobe/bit_in/line_out), instantiated only under TX_PTS_NRZI_EN.

Test Plan:
- Reset: n_rst = 1 for 2 clks -> serial_out = 1, data_ready = 1, busy = 0. Assert n_rst mid-word -> same values on the next edge.
- Load 8'hA5, MSB_FIRST = 0, strobe every 4 clks -> serial_out sequence 1,0,1,0,0,1,0,1; word_done pulses with the 8th bit; then idle 1.
- Load 8'hFF -> eight 1s with a stuffed 0 after the 6th: sequence 1,1,1,1,1,1,0,1,1. stuff_active pulses once. word_done aligns with the final 1.
- Back-to-back 8'h3F then 8'h81 (second loaded while the first shifts, so data_ready drops) -> after the six 1s of 3F a stuffed 0; no idle gap between words; two word_done pulses.
- Word 8'hFC (last six bits 1) -> stuffed 0 emitted on the strobe after word_done while active = 0; busy stays 1 until it is sent.
- With TX_PTS_NRZI_EN, load 8'h00 -> line toggles on every strobe starting 1 -> 0,1,0,1,0,1,0,1; idle strobes hold the level.
